// File: rtl/gps_feeder.sv
// Feeds buffered GPS points to a distance calculator one pair at a time and
// captures the calculator's results; the first point of a session only primes the pair.
module gps_feeder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [23:0] wr_lon,
  input  logic [23:0] wr_lat,
  output logic        full,
  output logic        DEN,
  output logic [23:0] LON_IN,
  output logic [23:0] LAT_IN,
  input  logic        Valid,
  input  logic [39:0] D,
  input  logic [63:0] a,
  output logic        res_valid,
  output logic [39:0] res_D,
  output logic [63:0] res_a,
  output logic [15:0] pair_cnt,
  output logic        err_timeout,
  output logic        err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  logic [47:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  state_t        state_r;
  logic          first_r;
  logic [TW-1:0] timer_r;

  assign empty_s = (count_r == {(AW+1){1'b0}});
  // full is the registered flag, so a pop in the same cycle never frees room for this write
  assign push_s  = wr_en & ~full & ~clr;
  // the head is popped on the edge that enters ISSUE, so DEN and the data appear together
  assign pop_s   = ~clr & ~empty_s & ((state_r == IDLE) | (state_r == GAP));

  // Occupancy after this edge's push and pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{AW{1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{AW{1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Point storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {wr_lon, wr_lat};
    end
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full     <= 1'b0;
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_next_s;
      full    <= (count_next_s == (AW+1)'(DEPTH));
    end
  end

  // Issue/wait sequencer with registered strobes, result capture and sticky errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      first_r      <= 1'b1;
      timer_r      <= {TW{1'b0}};
      DEN          <= 1'b0;
      LON_IN       <= 24'd0;
      LAT_IN       <= 24'd0;
      res_valid    <= 1'b0;
      res_D        <= 40'd0;
      res_a        <= 64'd0;
      pair_cnt     <= 16'd0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else if (clr) begin
      state_r      <= IDLE;
      first_r      <= 1'b1;
      timer_r      <= {TW{1'b0}};
      DEN          <= 1'b0;
      res_valid    <= 1'b0;
      pair_cnt     <= 16'd0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      DEN       <= 1'b0;
      res_valid <= 1'b0;
      if (wr_en && full) begin
        err_overflow <= 1'b1;
      end
      case (state_r)
        IDLE, GAP: begin
          if (!empty_s) begin
            state_r          <= ISSUE;
            DEN              <= 1'b1;
            {LON_IN, LAT_IN} <= mem_r[rd_ptr_r];
          end
        end
        ISSUE: begin
          if (first_r) begin
            first_r <= 1'b0;
            state_r <= GAP;
          end else begin
            timer_r <= {TW{1'b0}};
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (Valid) begin
            res_D     <= D;
            res_a     <= a;
            res_valid <= 1'b1;
            pair_cnt  <= pair_cnt + 16'd1;
            state_r   <= GAP;
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state_r     <= GAP;
          end else begin
            timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_feeder.sv
// Scoreboard bench for gps_feeder: expected points/results are queued when stimulus
// is issued and a negedge monitor pops and compares whenever DEN or res_valid fires.
module tb_gps_feeder;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset_n, clr, wr_en, full, DEN, Valid, res_valid, err_timeout, err_overflow;
  logic [23:0] wr_lon, wr_lat, LON_IN, LAT_IN;
  logic [39:0] D, res_D;
  logic [63:0] a, res_a;
  logic [15:0] pair_cnt;

  always #5 clk = ~clk;

  gps_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .wr_lon(wr_lon), .wr_lat(wr_lat),
    .full(full), .DEN(DEN), .LON_IN(LON_IN), .LAT_IN(LAT_IN), .Valid(Valid), .D(D), .a(a),
    .res_valid(res_valid), .res_D(res_D), .res_a(res_a), .pair_cnt(pair_cnt),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  typedef struct { logic [23:0] lon; logic [23:0] lat; } pt_t;
  typedef struct { logic [39:0] d; logic [63:0] av; logic [15:0] cnt; } res_t;

  pt_t         exp_pts[$];
  res_t        exp_res[$];
  pt_t         mon_p;
  res_t        mon_r;
  int          total = 0;
  int          bad = 0;
  int          den_seen = 0;
  int          den_target = 0;
  int          cyc = 0;
  int          den_cyc_last = 0;
  int          den_cyc_prev = 0;
  logic        prev_den = 1'b0;
  bit          session_first = 1'b1;
  logic [15:0] exp_cnt = 16'd0;
  logic [39:0] last_d = 40'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every DEN and res_valid is matched against the scoreboard queues.
  always @(negedge clk) begin
    cyc++;
    if (DEN) begin
      check("den_spacing", 64'(prev_den), 64'd0);
      if (exp_pts.size() == 0) begin
        total++;
        bad++;
        $display("FAIL den_unexpected: got DEN with %0h/%0h expected no DEN", LON_IN, LAT_IN);
      end else begin
        mon_p = exp_pts.pop_front();
        check("lon_in", 64'(LON_IN), 64'(mon_p.lon));
        check("lat_in", 64'(LAT_IN), 64'(mon_p.lat));
      end
      den_seen++;
      den_cyc_prev = den_cyc_last;
      den_cyc_last = cyc;
    end
    prev_den = DEN;
    if (res_valid) begin
      if (exp_res.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res_unexpected: got res_valid with D=%0h expected none", res_D);
      end else begin
        mon_r = exp_res.pop_front();
        check("res_d", 64'(res_D), 64'(mon_r.d));
        check("res_a", res_a, mon_r.av);
        check("pair_cnt_mon", 64'(pair_cnt), 64'(mon_r.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] lon, input logic [23:0] lat, input bit accept);
    pt_t p;
    wr_en  = 1'b1;
    wr_lon = lon;
    wr_lat = lat;
    if (accept) begin
      p.lon = lon;
      p.lat = lat;
      exp_pts.push_back(p);
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_rand(input bit accept);
    logic [31:0] r1, r2;
    r1 = $urandom();
    r2 = $urandom();
    push(r1[23:0], r2[23:0], accept);
  endtask

  task automatic wait_den();
    bit got;
    got = 1'b0;
    den_target++;
    for (int i = 0; i < 600 && !got; i++) begin
      if (den_seen >= den_target) got = 1'b1;
      else tick();
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL den_wait: got %0d DEN pulses expected %0d", den_seen, den_target);
      den_target = den_seen;
    end
  endtask

  task automatic pulse_valid(input logic [39:0] dv, input logic [63:0] av, input bit expect_res);
    res_t e;
    Valid = 1'b1;
    D     = dv;
    a     = av;
    if (expect_res) begin
      exp_cnt++;
      e.d   = dv;
      e.av  = av;
      e.cnt = exp_cnt;
      exp_res.push_back(e);
      last_d = dv;
    end
    tick();
    Valid = 1'b0;
  endtask

  task automatic pulse_rand(input bit expect_res);
    logic [63:0] r1, r2;
    r1 = {$urandom(), $urandom()};
    r2 = {$urandom(), $urandom()};
    pulse_valid(r1[39:0], r2, expect_res);
  endtask

  // Answers n issued points: first point of a session gets no answer, others get Valid.
  task automatic serve(input int n, input int dmax);
    int dly;
    for (int i = 0; i < n; i++) begin
      wait_den();
      if (session_first) begin
        session_first = 1'b0;
      end else begin
        dly = $urandom_range(dmax, 1);
        repeat (dly - 1) tick();
        pulse_rand(1'b1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_den"}, 64'(DEN), 64'd0);
    check({tag, "_lon"}, 64'(LON_IN), 64'd0);
    check({tag, "_lat"}, 64'(LAT_IN), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_d"}, 64'(res_D), 64'd0);
    check({tag, "_res_a"}, res_a, 64'd0);
    check({tag, "_pair_cnt"}, 64'(pair_cnt), 64'd0);
    check({tag, "_err_to"}, 64'(err_timeout), 64'd0);
    check({tag, "_err_ov"}, 64'(err_overflow), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    int k, snap;
    reset_n = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_lon = 24'd0; wr_lat = 24'd0;
    Valid = 1'b0; D = 40'd0; a = 64'd0;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick(); tick();

    // Valid in IDLE is ignored
    pulse_valid(40'h1, 64'h2, 1'b0);
    tick();
    check("idle_valid_cnt", 64'(pair_cnt), 64'd0);
    check("idle_valid_res", 64'(res_D), 64'd0);

    // Three points: first primes, second pairs, third pairs with the second
    push(24'h100001, 24'h200001, 1'b1);
    push(24'h100002, 24'h200002, 1'b1);
    push(24'h100003, 24'h200003, 1'b1);
    wait_den();
    session_first = 1'b0;
    wait_den();
    check("first_to_second_gap", 64'(den_cyc_last - den_cyc_prev), 64'd2);
    tick(); tick();
    pulse_valid(40'h12345, 64'hA5A5_0000_1234_5678, 1'b1);
    check("basic_res_d", 64'(res_D), 64'h12345);
    check("basic_cnt1", 64'(pair_cnt), 64'd1);
    wait_den();
    pulse_rand(1'b1);
    check("basic_cnt2", 64'(pair_cnt), 64'd2);

    // Valid while in GAP is ignored
    tick(); tick();
    pulse_valid(40'hDEAD, 64'hBEEF, 1'b0);
    tick();
    check("gap_valid_cnt", 64'(pair_cnt), 64'd2);
    check("gap_valid_res", 64'(res_D), 64'(last_d));

    // Randomized bursts in an open session
    for (int r = 0; r < 10; r++) begin
      k = $urandom_range(4, 1);
      for (int j = 0; j < k; j++) push_rand(1'b1);
      serve(k, 6);
    end
    check("rand_cnt", 64'(pair_cnt), 64'(exp_cnt));

    // Overflow: hold the sequencer in WAIT, then push DEPTH+1 points
    push_rand(1'b1);
    wait_den();
    for (int j = 0; j < DEPTH - 1; j++) push_rand(1'b1);
    check("full_before_last", 64'(full), 64'd0);
    push_rand(1'b1);
    check("full_at_depth", 64'(full), 64'd1);
    check("ov_before_drop", 64'(err_overflow), 64'd0);
    push_rand(1'b0);
    check("ov_set", 64'(err_overflow), 64'd1);
    check("full_after_drop", 64'(full), 64'd1);
    pulse_rand(1'b1);
    serve(DEPTH, 3);
    check("full_drained", 64'(full), 64'd0);

    // clr with a same-cycle write while three points wait in the FIFO
    push_rand(1'b1);
    wait_den();
    for (int j = 0; j < 3; j++) push_rand(1'b1);
    exp_pts.delete();
    session_first = 1'b1;
    exp_cnt = 16'd0;
    clr = 1'b1;
    push_rand(1'b0);
    clr = 1'b0;
    check("clr_full", 64'(full), 64'd0);
    check("clr_err_ov", 64'(err_overflow), 64'd0);
    check("clr_err_to", 64'(err_timeout), 64'd0);
    check("clr_pair_cnt", 64'(pair_cnt), 64'd0);
    check("clr_res_kept", 64'(res_D), 64'(last_d));
    snap = den_seen;
    repeat (6) tick();
    check("clr_no_issue", 64'(den_seen), 64'(snap));

    // Timeout: fresh session, second point never answered
    push(24'h0A0A0A, 24'h0B0B0B, 1'b1);
    push(24'h0C0C0C, 24'h0D0D0D, 1'b1);
    wait_den();
    session_first = 1'b0;
    wait_den();
    check("clr_first_gap", 64'(den_cyc_last - den_cyc_prev), 64'd2);
    repeat (TIMEOUT - 1) tick();
    check("timeout_not_yet", 64'(err_timeout), 64'd0);
    tick();
    check("timeout_set", 64'(err_timeout), 64'd1);
    check("timeout_cnt", 64'(pair_cnt), 64'd0);
    push(24'h0E0E0E, 24'h0F0F0F, 1'b1);
    wait_den();
    pulse_rand(1'b1);
    check("after_timeout_cnt", 64'(pair_cnt), 64'd1);

    // Reset during WAIT discards the in-flight point
    push_rand(1'b1);
    wait_den();
    tick(); tick();
    reset_n = 1'b0;
    exp_pts.delete();
    exp_res.delete();
    session_first = 1'b1;
    exp_cnt = 16'd0;
    den_target = den_seen;
    #1;
    check_reset_outputs("midreset");
    tick();
    reset_n = 1'b1;
    tick();
    push(24'h111111, 24'h222222, 1'b1);
    push(24'h333333, 24'h444444, 1'b1);
    wait_den();
    session_first = 1'b0;
    wait_den();
    check("reset_first_gap", 64'(den_cyc_last - den_cyc_prev), 64'd2);
    check("reset_no_res", 64'(res_valid), 64'd0);
    check("reset_res_d", 64'(res_D), 64'd0);
    check("reset_cnt", 64'(pair_cnt), 64'd0);
    pulse_rand(1'b1);
    check("reset_pair_cnt", 64'(pair_cnt), 64'd1);

    repeat (4) tick();
    check("pts_drained", 64'(exp_pts.size()), 64'd0);
    check("res_drained", 64'(exp_res.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
